param_reg_bank: RTL and testbench

Parametrised bank of NREGS general-purpose registers, each WIDTH bits, sharing one function-select bus and one data input, with per-register write enables and two combinational read ports. It is the generalised successor of the single 32-bit function-select register and sits between the ALU/memory data path and the operand multiplexers. Each register also has a byte-assembly counter that raises Full once a whole word has been shifted in byte by byte. Increment and decrement report wrap-around as a one-cycle flag.

---
 rtl/param_reg_bank.sv | 71 +++++++
 tb/tb_param_reg_bank.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/param_reg_bank.sv
// param_reg_bank: NREGS x WIDTH register bank with shared function select, byte assembly (Full), wrap pulses (Wrap); REGFILE_BYPASS_EN enables write-through read forwarding
module param_reg_bank #(
  parameter int WIDTH = 32,
  parameter int NREGS = 4,
  parameter int SELW = $clog2(NREGS)
) (
  input  logic             Clock,
  input  logic             rst,
  input  logic [NREGS-1:0] E,
  input  logic [2:0]       FunSel,
  input  logic [WIDTH-1:0] I,
  input  logic [SELW-1:0]  OutASel,
  input  logic [SELW-1:0]  OutBSel,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB,
  output logic [NREGS-1:0] Full,
  output logic [NREGS-1:0] Wrap
);
  localparam int NB = WIDTH / 8;
  localparam int CW = $clog2(NB + 1);
  localparam logic [CW-1:0] CMAX = CW'(NB);
  logic [NREGS-1:0][WIDTH-1:0] q, nq;
  logic [NREGS-1:0][CW-1:0] cnt, ncnt;
  logic [NREGS-1:0] nwrap;
  // next register value, byte count and wrap flag; unenabled registers hold
  always_comb begin
    nq = q;
    ncnt = cnt;
    nwrap = '0;
    for (int k = 0; k < NREGS; k++) begin
      if (E[k]) begin
        case (FunSel)
          3'b000:  nq[k] = q[k] - WIDTH'(1);
          3'b001:  nq[k] = q[k] + WIDTH'(1);
          3'b010:  nq[k] = I;
          3'b011:  nq[k] = '0;
          3'b100:  nq[k] = WIDTH'(I[7:0]);
          3'b101:  nq[k] = WIDTH'(I[15:0]);
          3'b110:  nq[k] = {q[k][WIDTH-9:0], I[7:0]};
          default: nq[k] = WIDTH'($signed(I[15:0]));
        endcase
        ncnt[k] = FunSel == 3'b110 ? (cnt[k] == CMAX ? cnt[k] : cnt[k] + CW'(1)) : '0;
        nwrap[k] = (FunSel == 3'b001 && &q[k]) || (FunSel == 3'b000 && q[k] == '0);
      end
    end
  end
  // state update; reset overrides every enable
  always_ff @(posedge Clock) begin
    if (rst) begin
      q <= '0;
      cnt <= '0;
      Wrap <= '0;
    end else begin
      q <= nq;
      cnt <= ncnt;
      Wrap <= nwrap;
    end
  end
  // a register is full once a whole word of bytes has been shifted in
  always_comb begin
    Full = '0;
    for (int k = 0; k < NREGS; k++) Full[k] = cnt[k] == CMAX;
  end
`ifdef REGFILE_BYPASS_EN
  assign OutA = nq[OutASel];
  assign OutB = nq[OutBSel];
`else
  assign OutA = q[OutASel];
  assign OutB = q[OutBSel];
`endif
endmodule

// File: tb/tb_param_reg_bank.sv
// tb_param_reg_bank: directed and randomized checks of param_reg_bank against a behavioural model
module tb_param_reg_bank;
  localparam int W = 32;
  localparam int N = 4;
  logic Clock = 1'b0;
  logic rst;
  logic [N-1:0] E;
  logic [2:0] FunSel;
  logic [W-1:0] I;
  logic [1:0] OutASel, OutBSel;
  logic [W-1:0] OutA, OutB;
  logic [N-1:0] Full, Wrap;
  int total = 0;
  int bad = 0;
  logic [W-1:0] mq[N];
  int mc[N];
  logic [N-1:0] mw;
  logic [N-1:0] mfull;
  always #5 Clock = ~Clock;
  param_reg_bank #(.WIDTH(W), .NREGS(N)) dut (
    .Clock(Clock), .rst(rst), .E(E), .FunSel(FunSel), .I(I),
    .OutASel(OutASel), .OutBSel(OutBSel), .OutA(OutA), .OutB(OutB),
    .Full(Full), .Wrap(Wrap)
  );
  function automatic logic [W-1:0] ref_op(logic [W-1:0] q, logic [2:0] f, logic [W-1:0] d);
    longint unsigned v = q;
    longint unsigned x = d;
    longint unsigned m = 64'd1 << W;
    case (f)
      3'd0: return W'((v + m - 1) % m);
      3'd1: return W'((v + 1) % m);
      3'd2: return d;
      3'd3: return '0;
      3'd4: return W'(x % 256);
      3'd5: return W'(x % 65536);
      3'd6: return W'((v * 256 + x % 256) % m);
      default: return (x % 65536) >= 32768 ? W'(m - 65536 + x % 65536) : W'(x % 65536);
    endcase
  endfunction
  task automatic step(input logic r, input logic [N-1:0] e, input logic [2:0] f, input logic [W-1:0] d);
    rst = r; E = e; FunSel = f; I = d;
    @(posedge Clock);
    for (int k = 0; k < N; k++) begin
      if (r) begin
        mq[k] = '0; mc[k] = 0; mw[k] = 1'b0;
      end else begin
        mw[k] = e[k] && ((f == 3'd1 && mq[k] == {W{1'b1}}) || (f == 3'd0 && mq[k] == '0));
        if (e[k]) begin
          mc[k] = f == 3'd6 ? (mc[k] < W / 8 ? mc[k] + 1 : mc[k]) : 0;
          mq[k] = ref_op(mq[k], f, d);
        end
      end
      mfull[k] = mc[k] == W / 8;
    end
    #1;
    rst = 1'b0; E = '0;
  endtask
  task automatic rd(input int k, output logic [W-1:0] v);
    OutASel = 2'(k); OutBSel = 2'(N - 1 - k);
    #1;
    v = OutA;
  endtask
  task automatic test_reset;
    step(0, 4'b1111, 3'd2, 32'hDEADBEEF);
    step(0, 4'b0011, 3'd6, 32'h12);
    step(1, 4'b1111, 3'd2, 32'h12345678);
    for (int k = 0; k < N; k++) begin
      OutASel = 2'(k); OutBSel = 2'(k);
      #1;
      total++;
      if (OutA !== '0 || OutB !== '0) begin
        bad++; $display("FAIL reset_read[%0d] got A=%h B=%h exp 0", k, OutA, OutB);
      end
    end
    total++;
    if (Full !== 4'b0000 || Wrap !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got Full=%b Wrap=%b exp 0000/0000", Full, Wrap);
    end
  endtask
  task automatic test_wrap;
    logic [W-1:0] v;
    step(0, 4'b0100, 3'd2, 32'hFFFFFFFF);
    total++;
    if (Wrap !== 4'b0000) begin bad++; $display("FAIL wrap_after_load got %b exp 0000", Wrap); end
    step(0, 4'b0100, 3'd1, 32'h0);
    rd(2, v);
    total++;
    if (v !== 32'h0 || Wrap !== 4'b0100) begin
      bad++; $display("FAIL wrap_inc got R2=%h Wrap=%b exp 00000000/0100", v, Wrap);
    end
    step(0, 4'b0000, 3'd1, 32'h0);
    total++;
    if (Wrap !== 4'b0000) begin bad++; $display("FAIL wrap_pulse got %b exp 0000", Wrap); end
    step(0, 4'b0100, 3'd0, 32'h0);
    rd(2, v);
    total++;
    if (v !== 32'hFFFFFFFF || Wrap !== 4'b0100) begin
      bad++; $display("FAIL wrap_dec got R2=%h Wrap=%b exp ffffffff/0100", v, Wrap);
    end
    step(0, 4'b0100, 3'd0, 32'h0);
    total++;
    if (Wrap !== 4'b0000) begin bad++; $display("FAIL wrap_nodec got %b exp 0000", Wrap); end
  endtask
  task automatic test_bytes;
    logic [W-1:0] v;
    logic [7:0] b[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    step(1, '0, 3'd0, '0);
    for (int j = 0; j < 3; j++) begin
      step(0, 4'b0010, 3'd6, {24'hABCDEF, b[j]});
      total++;
      if (Full[1] !== 1'b0) begin bad++; $display("FAIL bytes_early[%0d] got Full=%b exp Full[1]=0", j, Full); end
    end
    step(0, 4'b0010, 3'd6, {24'h0, b[3]});
    rd(1, v);
    total++;
    if (v !== 32'h11223344 || Full !== 4'b0010) begin
      bad++; $display("FAIL bytes_full got R1=%h Full=%b exp 11223344/0010", v, Full);
    end
    step(0, 4'b0010, 3'd6, {24'h0, b[4]});
    rd(1, v);
    total++;
    if (v !== 32'h22334455 || Full !== 4'b0010) begin
      bad++; $display("FAIL bytes_fifth got R1=%h Full=%b exp 22334455/0010", v, Full);
    end
    step(0, 4'b0010, 3'd3, '0);
    total++;
    if (Full !== 4'b0000) begin bad++; $display("FAIL bytes_clear got Full=%b exp 0000", Full); end
  endtask
  task automatic test_extend;
    logic [W-1:0] v0, v1, v2, v3;
    step(0, 4'b0010, 3'd2, 32'h1111);
    step(0, 4'b0100, 3'd2, 32'h2222);
    step(0, 4'b1001, 3'd7, 32'h00008001);
    rd(0, v0); rd(3, v3);
    total++;
    if (v0 !== 32'hFFFF8001 || v3 !== 32'hFFFF8001) begin
      bad++; $display("FAIL extend_sign got R0=%h R3=%h exp ffff8001", v0, v3);
    end
    step(0, 4'b1001, 3'd4, 32'h00008001);
    rd(0, v0); rd(1, v1); rd(2, v2); rd(3, v3);
    total++;
    if (v0 !== 32'h1 || v3 !== 32'h1 || v1 !== 32'h1111 || v2 !== 32'h2222) begin
      bad++; $display("FAIL extend_zero got R0=%h R1=%h R2=%h R3=%h exp 1/1111/2222/1", v0, v1, v2, v3);
    end
    step(0, 4'b0001, 3'd5, 32'hABCD9876);
    rd(0, v0);
    total++;
    if (v0 !== 32'h00009876) begin bad++; $display("FAIL extend_half got %h exp 00009876", v0); end
  endtask
  task automatic test_reset_mid;
    logic [W-1:0] v;
    step(0, 4'b0001, 3'd6, 32'hAA);
    step(0, 4'b0001, 3'd6, 32'hBB);
    step(1, 4'b0000, 3'd0, '0);
    rd(0, v);
    total++;
    if (v !== '0 || Full !== 4'b0000) begin bad++; $display("FAIL rstmid got R0=%h Full=%b exp 0/0000", v, Full); end
    for (int j = 0; j < 4; j++) begin
      step(0, 4'b0001, 3'd6, 32'(j + 1));
      total++;
      if (Full[0] !== (j == 3)) begin bad++; $display("FAIL rstmid_count[%0d] got Full[0]=%b exp %0d", j, Full[0], j == 3); end
    end
  endtask
  task automatic test_bypass;
    logic [W-1:0] old, ex;
    step(0, 4'b0100, 3'd2, 32'h5A5A0000);
    old = mq[2];
    OutASel = 2'd2; OutBSel = 2'd0; E = 4'b0100; FunSel = 3'd2; I = 32'hA5A5A5A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    ex = 32'hA5A5A5A5;
`else
    ex = old;
`endif
    total++;
    if (OutA !== ex) begin bad++; $display("FAIL bypass_pre got %h exp %h", OutA, ex); end
    step(0, 4'b0100, 3'd2, 32'hA5A5A5A5);
    total++;
    if (OutA !== 32'hA5A5A5A5) begin bad++; $display("FAIL bypass_post got %h exp a5a5a5a5", OutA); end
  endtask
  task automatic test_random;
    logic [N-1:0] e;
    logic [2:0] f;
    logic [W-1:0] d, ea, eb;
    logic r;
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 40) == 0;
      e = N'($urandom);
      f = 3'($urandom);
      d = $urandom_range(0, 7) == 0 ? 32'($urandom_range(0, 2)) : 32'($urandom);
      if ($urandom_range(0, 5) == 0) d = {W{1'b1}};
      OutASel = 2'($urandom); OutBSel = 2'($urandom);
      rst = 1'b0; E = e; FunSel = f; I = d;
      #1;
      ea = mq[OutASel]; eb = mq[OutBSel];
`ifdef REGFILE_BYPASS_EN
      if (e[OutASel]) ea = ref_op(mq[OutASel], f, d);
      if (e[OutBSel]) eb = ref_op(mq[OutBSel], f, d);
`endif
      total++;
      if (OutA !== ea || OutB !== eb) begin
        bad++; $display("FAIL rand_pre[%0d] got A=%h B=%h exp A=%h B=%h", it, OutA, OutB, ea, eb);
      end
      step(r, e, f, d);
      total++;
      if (OutA !== mq[OutASel] || OutB !== mq[OutBSel] || Full !== mfull || Wrap !== mw) begin
        bad++; $display("FAIL rand_post[%0d] got A=%h B=%h Full=%b Wrap=%b exp A=%h B=%h Full=%b Wrap=%b",
          it, OutA, OutB, Full, Wrap, mq[OutASel], mq[OutBSel], mfull, mw);
      end
      if ($urandom_range(0, 3) == 0) begin
        for (int j = 0; j < 4; j++) step(0, 4'($urandom), 3'd6, 32'($urandom));
      end
    end
  endtask
  initial begin
    rst = 1'b1; E = '0; FunSel = '0; I = '0; OutASel = '0; OutBSel = '0;
    for (int k = 0; k < N; k++) begin mq[k] = '0; mc[k] = 0; end
    mw = '0; mfull = '0;
    @(negedge Clock);
    test_reset();
    test_wrap();
    test_bytes();
    test_extend();
    test_reset_mid();
    test_bypass();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
